spu_mul_req_seq: RTL and testbench



---
 rtl/spu_mul_req_seq_if.sv | 54 +++++
 rtl/spu_mul_req_seq.sv | 189 ++++++++++++++++++
 tb/tb_spu_mul_req_seq.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spu_mul_req_seq_if.sv
// rtl/spu_mul_req_seq_if.sv - command, multiplier request/ack and result bundle for spu_mul_req_seq
`timescale 1ns/1ps
interface spu_mul_req_seq_if #(
    parameter int unsigned CNT_W = 8
);
    // SPU command port
    logic             cmd_vld;
    logic             cmd_rdy;
    logic [1:0]       cmd_type;
    logic             cmd_lshft;
    logic [63:0]      cmd_op1;
    logic [63:0]      cmd_op2;
    // multiplier request side
    logic             spu_mul_req_vld;
    logic             spu_mul_acc;
    logic             spu_mul_areg_shf;
    logic             spu_mul_areg_rst;
    logic             spu_mul_mulres_lshft;
    logic [63:0]      spu_mul_op1_data;
    logic [63:0]      spu_mul_op2_data;
    // multiplier response side
    logic             mul_spu_ack;
    logic             mul_spu_shf_ack;
    logic [63:0]      mul_data_out;
    // result / status
    logic             res_vld;
    logic             res_rdy;
    logic [63:0]      res_data;
    logic [CNT_W-1:0] done_cnt;
    logic [1:0]       err;
    logic             err_clr;

    // sequencer view
    modport master (
        input  cmd_vld, cmd_type, cmd_lshft, cmd_op1, cmd_op2,
        input  mul_spu_ack, mul_spu_shf_ack, mul_data_out,
        input  res_rdy, err_clr,
        output cmd_rdy,
        output spu_mul_req_vld, spu_mul_acc, spu_mul_areg_shf, spu_mul_areg_rst,
        output spu_mul_mulres_lshft, spu_mul_op1_data, spu_mul_op2_data,
        output res_vld, res_data, done_cnt, err
    );

    // environment view (SPU control + multiplier)
    modport slave (
        output cmd_vld, cmd_type, cmd_lshft, cmd_op1, cmd_op2,
        output mul_spu_ack, mul_spu_shf_ack, mul_data_out,
        output res_rdy, err_clr,
        input  cmd_rdy,
        input  spu_mul_req_vld, spu_mul_acc, spu_mul_areg_shf, spu_mul_areg_rst,
        input  spu_mul_mulres_lshft, spu_mul_op1_data, spu_mul_op2_data,
        input  res_vld, res_data, done_cnt, err
    );
endinterface

// File: rtl/spu_mul_req_seq.sv
// rtl/spu_mul_req_seq.sv - SPU request sequencer for the shared multiplier (ack timeout under SPU_MUL_TIMEOUT_EN)
`timescale 1ns/1ps
module spu_mul_req_seq #(
`ifdef SPU_MUL_TIMEOUT_EN
    parameter int unsigned ACK_TIMEOUT = 64,
`endif
    parameter int unsigned CNT_W = 8
) (
    input  logic             rclk,
    input  logic             arst_l,
    spu_mul_req_seq_if.master bus
);

    localparam logic [1:0] CMD_MAC    = 2'd0;
    localparam logic [1:0] CMD_BYP    = 2'd1;
    localparam logic [1:0] CMD_SHF    = 2'd2;
    localparam logic [1:0] CMD_ACCRST = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_SHF  = 2'd2,
        S_ARST = 2'd3
    } state_t;

    state_t           state_q;
    logic             req_vld_q;
    logic             acc_q;
    logic             areg_shf_q;
    logic             areg_rst_q;
    logic             lshft_q;
    logic [63:0]      op1_q;
    logic [63:0]      op2_q;
    logic             res_vld_q;
    logic [63:0]      res_data_q;
    logic [CNT_W-1:0] done_cnt_q;
    logic [1:0]       err_q;
    logic [1:0]       err_d;
    logic [1:0]       err_set;
    logic             cmd_rdy;
    logic             accept;
    logic             to_hit;

    // a pending result blocks new commands unless it is being consumed this cycle
    assign cmd_rdy = (state_q == S_IDLE) && (!res_vld_q || bus.res_rdy);
    assign accept  = bus.cmd_vld && cmd_rdy;

`ifdef SPU_MUL_TIMEOUT_EN
    localparam int unsigned TO_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    logic [TO_W-1:0] to_cnt_q;

    // wait counter: zero while idle so it starts at 0 on entry to REQ/SHF
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            to_cnt_q <= '0;
        end else if (state_q == S_REQ || state_q == S_SHF) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_q <= '0;
        end
    end

    assign to_hit = (to_cnt_q == TO_W'(ACK_TIMEOUT - 1));
`else
    assign to_hit = 1'b0;
`endif

    // request FSM with all multiplier-facing outputs and the result held in registers
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state_q    <= S_IDLE;
            req_vld_q  <= 1'b0;
            acc_q      <= 1'b0;
            areg_shf_q <= 1'b0;
            areg_rst_q <= 1'b0;
            lshft_q    <= 1'b0;
            op1_q      <= '0;
            op2_q      <= '0;
            res_vld_q  <= 1'b0;
            res_data_q <= '0;
            done_cnt_q <= '0;
        end else begin
            if (res_vld_q && bus.res_rdy) begin
                res_vld_q <= 1'b0;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op1_q   <= bus.cmd_op1;
                        op2_q   <= bus.cmd_op2;
                        lshft_q <= bus.cmd_lshft;
                        unique case (bus.cmd_type)
                            CMD_MAC, CMD_BYP: begin
                                state_q   <= S_REQ;
                                req_vld_q <= 1'b1;
                                acc_q     <= (bus.cmd_type == CMD_MAC);
                            end
                            CMD_SHF: begin
                                state_q    <= S_SHF;
                                areg_shf_q <= 1'b1;
                            end
                            CMD_ACCRST: begin
                                state_q    <= S_ARST;
                                areg_rst_q <= 1'b1;
                            end
                            default: state_q <= S_IDLE;
                        endcase
                    end
                end
                S_REQ: begin
                    // mul_spu_ack wins even when a shift ack arrives alongside it
                    if (bus.mul_spu_ack) begin
                        state_q    <= S_IDLE;
                        req_vld_q  <= 1'b0;
                        acc_q      <= 1'b0;
                        res_vld_q  <= 1'b1;
                        res_data_q <= bus.mul_data_out;
                        done_cnt_q <= done_cnt_q + CNT_W'(1);
                    end else if (to_hit) begin
                        state_q   <= S_IDLE;
                        req_vld_q <= 1'b0;
                        acc_q     <= 1'b0;
                    end
                end
                S_SHF: begin
                    if (bus.mul_spu_shf_ack) begin
                        state_q    <= S_IDLE;
                        areg_shf_q <= 1'b0;
                        res_vld_q  <= 1'b1;
                        res_data_q <= bus.mul_data_out;
                        done_cnt_q <= done_cnt_q + CNT_W'(1);
                    end else if (to_hit) begin
                        state_q    <= S_IDLE;
                        areg_shf_q <= 1'b0;
                    end
                end
                S_ARST: begin
                    // accumulator reset is a single-cycle pulse with no ack
                    state_q    <= S_IDLE;
                    areg_rst_q <= 1'b0;
                    done_cnt_q <= done_cnt_q + CNT_W'(1);
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // sticky error events: acks nobody asked for, and abandoned requests
    always_comb begin
        err_set = 2'b00;
        unique case (state_q)
            S_REQ: begin
                err_set[1] = bus.mul_spu_shf_ack;
                err_set[0] = to_hit && !bus.mul_spu_ack;
            end
            S_SHF: begin
                err_set[1] = bus.mul_spu_ack;
                err_set[0] = to_hit && !bus.mul_spu_shf_ack;
            end
            default: begin
                err_set[1] = bus.mul_spu_ack || bus.mul_spu_shf_ack;
            end
        endcase
        err_d = (err_q & ~{2{bus.err_clr}}) | err_set;
    end

    // error register; a new event outranks a simultaneous clear
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            err_q <= 2'b00;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.cmd_rdy              = cmd_rdy;
    assign bus.spu_mul_req_vld      = req_vld_q;
    assign bus.spu_mul_acc          = acc_q;
    assign bus.spu_mul_areg_shf     = areg_shf_q;
    assign bus.spu_mul_areg_rst     = areg_rst_q;
    assign bus.spu_mul_mulres_lshft = lshft_q;
    assign bus.spu_mul_op1_data     = op1_q;
    assign bus.spu_mul_op2_data     = op2_q;
    assign bus.res_vld              = res_vld_q;
    assign bus.res_data             = res_data_q;
    assign bus.done_cnt             = done_cnt_q;
    assign bus.err                  = err_q;

endmodule

// File: tb/tb_spu_mul_req_seq.sv
// tb/tb_spu_mul_req_seq.sv - self-checking bench for spu_mul_req_seq
`timescale 1ns/1ps
module tb_spu_mul_req_seq;

    localparam int CNT_W = 8;
    localparam logic [1:0] T_MAC = 2'd0;
    localparam logic [1:0] T_BYP = 2'd1;
    localparam logic [1:0] T_SHF = 2'd2;
    localparam logic [1:0] T_RST = 2'd3;

    typedef struct {
        logic [1:0]  ty;
        logic [63:0] o1;
        logic [63:0] o2;
        logic        ls;
        int          dly;
        logic [63:0] data;
        int          stall;
        logic        exp_acc;
        logic [63:0] exp_res;
    } vec_t;

    logic rclk   = 1'b0;
    logic arst_l = 1'b0;
    int   tests  = 0;
    int   fails  = 0;
    int   exp_done = 0;
    logic [1:0] exp_err = 2'b00;
    vec_t vecs[7];

    spu_mul_req_seq_if #(.CNT_W(CNT_W)) bus();

`ifdef SPU_MUL_TIMEOUT_EN
    spu_mul_req_seq #(.ACK_TIMEOUT(8), .CNT_W(CNT_W)) dut (.rclk(rclk), .arst_l(arst_l), .bus(bus));
`else
    spu_mul_req_seq #(.CNT_W(CNT_W)) dut (.rclk(rclk), .arst_l(arst_l), .bus(bus));
`endif

    always #5 rclk = ~rclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not terminate");
    end

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_rdy"}, bus.cmd_rdy, 1);
        chk({tag, "_req_vld"}, bus.spu_mul_req_vld, 0);
        chk({tag, "_acc"}, bus.spu_mul_acc, 0);
        chk({tag, "_areg_shf"}, bus.spu_mul_areg_shf, 0);
        chk({tag, "_areg_rst"}, bus.spu_mul_areg_rst, 0);
        chk({tag, "_lshft"}, bus.spu_mul_mulres_lshft, 0);
        chk({tag, "_op1"}, bus.spu_mul_op1_data, 0);
        chk({tag, "_op2"}, bus.spu_mul_op2_data, 0);
        chk({tag, "_res_vld"}, bus.res_vld, 0);
        chk({tag, "_res_data"}, bus.res_data, 0);
        chk({tag, "_done_cnt"}, bus.done_cnt, 0);
        chk({tag, "_err"}, bus.err, 0);
    endtask

    // One command from acceptance to result. stall>0: hold result that many cycles, then
    // consume it alone; stall<0: leave it pending for the next command to consume.
    task automatic run_op(input logic [1:0] ty, input logic [63:0] o1, input logic [63:0] o2,
                          input logic ls, input int dly, input logic [63:0] data, input int stall,
                          input logic exp_acc, input logic [63:0] exp_res);
        bus.res_rdy   = 1'b1;
        bus.cmd_vld   = 1'b1;
        bus.cmd_type  = ty;
        bus.cmd_op1   = o1;
        bus.cmd_op2   = o2;
        bus.cmd_lshft = ls;
        #1;
        chk("cmd_rdy_accept", bus.cmd_rdy, 1);
        tick();
        bus.cmd_vld   = 1'b0;
        bus.cmd_op1   = ~o1;
        bus.cmd_op2   = ~o2;
        bus.cmd_lshft = ~ls;
        if (ty == T_RST) begin
            chk("areg_rst_pulse", bus.spu_mul_areg_rst, 1);
            chk("req_vld_in_arst", bus.spu_mul_req_vld, 0);
            chk("cmd_rdy_in_arst", bus.cmd_rdy, 0);
            tick();
            exp_done++;
            chk("areg_rst_end", bus.spu_mul_areg_rst, 0);
            chk("done_cnt_arst", bus.done_cnt, exp_done % 256);
            chk("res_vld_arst", bus.res_vld, 0);
            chk("cmd_rdy_after_arst", bus.cmd_rdy, 1);
            return;
        end
        bus.res_rdy = (stall == 0);
        for (int i = 0; i <= dly; i++) begin
            chk("req_vld_hold", bus.spu_mul_req_vld, ty != T_SHF);
            chk("areg_shf_hold", bus.spu_mul_areg_shf, ty == T_SHF);
            chk("acc_hold", bus.spu_mul_acc, exp_acc);
            chk("op1_hold", bus.spu_mul_op1_data, o1);
            chk("op2_hold", bus.spu_mul_op2_data, o2);
            chk("lshft_hold", bus.spu_mul_mulres_lshft, ls);
            chk("cmd_rdy_busy", bus.cmd_rdy, 0);
            chk("res_vld_busy", bus.res_vld, 0);
            if (i == dly) begin
                if (ty == T_SHF) bus.mul_spu_shf_ack = 1'b1;
                else             bus.mul_spu_ack     = 1'b1;
                bus.mul_data_out = data;
            end
            tick();
        end
        bus.mul_spu_ack     = 1'b0;
        bus.mul_spu_shf_ack = 1'b0;
        bus.mul_data_out    = {$urandom, $urandom};
        exp_done++;
        chk("req_vld_done", bus.spu_mul_req_vld, 0);
        chk("areg_shf_done", bus.spu_mul_areg_shf, 0);
        chk("res_vld_done", bus.res_vld, 1);
        chk("res_data", bus.res_data, exp_res);
        chk("done_cnt", bus.done_cnt, exp_done % 256);
        chk("err_op", bus.err, exp_err);
        if (stall == 0) begin
            chk("cmd_rdy_consume", bus.cmd_rdy, 1);
        end else if (stall < 0) begin
            chk("cmd_rdy_blocked", bus.cmd_rdy, 0);
        end else begin
            for (int i = 0; i < stall; i++) begin
                chk("cmd_rdy_stall", bus.cmd_rdy, 0);
                chk("res_vld_stall", bus.res_vld, 1);
                chk("res_data_stall", bus.res_data, exp_res);
                tick();
            end
            bus.res_rdy = 1'b1;
            #1;
            chk("cmd_rdy_release", bus.cmd_rdy, 1);
            tick();
            chk("res_vld_consumed", bus.res_vld, 0);
        end
    endtask

`ifdef SPU_MUL_TIMEOUT_EN
    task automatic timeout_op(input logic [1:0] ty);
        bus.res_rdy  = 1'b1;
        bus.cmd_vld  = 1'b1;
        bus.cmd_type = ty;
        bus.cmd_op1  = {$urandom, $urandom};
        bus.cmd_op2  = {$urandom, $urandom};
        #1;
        chk("to_cmd_rdy", bus.cmd_rdy, 1);
        tick();
        bus.cmd_vld = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("to_line_held", (ty == T_SHF) ? bus.spu_mul_areg_shf : bus.spu_mul_req_vld, 1);
            tick();
        end
        exp_err[0] = 1'b1;
        chk("to_line_drop", (ty == T_SHF) ? bus.spu_mul_areg_shf : bus.spu_mul_req_vld, 0);
        chk("to_err", bus.err, exp_err);
        chk("to_res_vld", bus.res_vld, 0);
        chk("to_done_cnt", bus.done_cnt, exp_done % 256);
        chk("to_cmd_rdy_after", bus.cmd_rdy, 1);
        bus.mul_spu_ack = 1'b1;
        tick();
        bus.mul_spu_ack = 1'b0;
        exp_err[1] = 1'b1;
        chk("to_stray_ack_err", bus.err, exp_err);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        exp_err = 2'b00;
        chk("to_err_clr", bus.err, exp_err);
    endtask
`endif

    initial begin
        logic [1:0]  rty;
        logic [63:0] rdata;
        int          rstall;

        bus.cmd_vld = 0; bus.cmd_type = 0; bus.cmd_lshft = 0; bus.cmd_op1 = 0; bus.cmd_op2 = 0;
        bus.mul_spu_ack = 0; bus.mul_spu_shf_ack = 0; bus.mul_data_out = 0;
        bus.res_rdy = 1; bus.err_clr = 0;

        vecs[0] = '{T_MAC, 64'd3, 64'd5, 1'b0, 3, 64'hF, 0, 1'b1, 64'hF};
        vecs[1] = '{T_BYP, 64'h1234, 64'h55, 1'b1, 0, 64'hDEAD, -1, 1'b0, 64'hDEAD};
        vecs[2] = '{T_MAC, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 1'b0, 1, 64'h1_0000_0000, 0, 1'b1, 64'h1_0000_0000};
        vecs[3] = '{T_RST, 64'h0, 64'h0, 1'b0, 0, 64'h0, 0, 1'b0, 64'h0};
        vecs[4] = '{T_SHF, 64'h77, 64'h88, 1'b0, 1, 64'hABCD, 0, 1'b0, 64'hABCD};
        vecs[5] = '{T_BYP, 64'hA5A5, 64'h5A5A, 1'b0, 2, 64'h8000_0000_0000_0001, 2, 1'b0, 64'h8000_0000_0000_0001};
        vecs[6] = '{T_SHF, 64'h1, 64'h2, 1'b1, 0, 64'h0, 0, 1'b0, 64'h0};

        // reset
        tick(); tick();
        chk_reset_vals("rst");
        arst_l = 1'b1;
        tick();
        chk_reset_vals("post_rst");

        // directed table
        foreach (vecs[k]) begin
            run_op(vecs[k].ty, vecs[k].o1, vecs[k].o2, vecs[k].ls, vecs[k].dly,
                   vecs[k].data, vecs[k].stall, vecs[k].exp_acc, vecs[k].exp_res);
        end

        // spurious ack in IDLE
        bus.mul_spu_ack = 1'b1;
        tick();
        bus.mul_spu_ack = 1'b0;
        exp_err = 2'b10;
        chk("idle_ack_err", bus.err, exp_err);

        // shift ack during a MAC is ignored apart from the error flag
        bus.cmd_vld = 1'b1; bus.cmd_type = T_MAC; bus.cmd_op1 = 64'd7; bus.cmd_op2 = 64'd9;
        tick();
        bus.cmd_vld = 1'b0;
        bus.mul_spu_shf_ack = 1'b1;
        bus.mul_data_out = 64'h1111;
        tick();
        bus.mul_spu_shf_ack = 1'b0;
        chk("wrong_ack_req_held", bus.spu_mul_req_vld, 1);
        chk("wrong_ack_no_res", bus.res_vld, 0);
        chk("wrong_ack_err", bus.err, exp_err);
        // both acks together: MAC completes, error flagged
        bus.mul_spu_ack = 1'b1; bus.mul_spu_shf_ack = 1'b1; bus.mul_data_out = 64'd63;
        tick();
        bus.mul_spu_ack = 1'b0; bus.mul_spu_shf_ack = 1'b0;
        exp_done++;
        chk("dual_ack_res_vld", bus.res_vld, 1);
        chk("dual_ack_res_data", bus.res_data, 64'd63);
        chk("dual_ack_done", bus.done_cnt, exp_done % 256);
        chk("dual_ack_req_drop", bus.spu_mul_req_vld, 0);
        // set event wins against a simultaneous clear
        bus.err_clr = 1'b1; bus.mul_spu_shf_ack = 1'b1;
        tick();
        bus.mul_spu_shf_ack = 1'b0;
        chk("set_beats_clr", bus.err, 2'b10);
        tick();
        bus.err_clr = 1'b0;
        exp_err = 2'b00;
        chk("err_clr", bus.err, exp_err);

`ifdef SPU_MUL_TIMEOUT_EN
        timeout_op(T_MAC);
        timeout_op(T_SHF);
`else
        // without the timeout the request waits as long as needed
        run_op(T_BYP, 64'd11, 64'd13, 1'b0, 70, 64'd143, 0, 1'b0, 64'd143);
`endif

        // randomized ops against the transaction-level model
        for (int n = 0; n < 40; n++) begin
            rty    = 2'($urandom_range(0, 3));
            rdata  = {$urandom, $urandom};
            rstall = int'($urandom_range(0, 4)) - 1;
            run_op(rty, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 5)), rdata, rstall, rty == T_MAC, rdata);
        end
        run_op(T_MAC, 64'd2, 64'd2, 1'b0, 0, 64'd4, 0, 1'b1, 64'd4);

        // counter wrap
        while (exp_done < 260) begin
            run_op(T_RST, 64'd0, 64'd0, 1'b0, 0, 64'd0, 0, 1'b0, 64'd0);
        end

        // asynchronous reset in the middle of a request
        bus.cmd_vld = 1'b1; bus.cmd_type = T_MAC; bus.cmd_op1 = 64'h99; bus.cmd_op2 = 64'h42;
        bus.cmd_lshft = 1'b1;
        tick();
        bus.cmd_vld = 1'b0; bus.cmd_lshft = 1'b0;
        tick();
        chk("pre_arst_req", bus.spu_mul_req_vld, 1);
        #3;
        arst_l = 1'b0;
        #1;
        chk_reset_vals("mid_arst");
        tick();
        arst_l = 1'b1;
        exp_done = 0;
        bus.mul_spu_ack = 1'b1;
        tick();
        bus.mul_spu_ack = 1'b0;
        chk("late_ack_err", bus.err, 2'b10);
        chk("late_ack_no_res", bus.res_vld, 0);
        chk("late_ack_done", bus.done_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
